// File: rtl/nfa_match_reporter.sv
// nfa_match_reporter: turns first-match rises of the sticky engine outputs into
// {vector, byte offset, packet number} events, buffered in a small FIFO.
module nfa_match_reporter #(
  parameter int unsigned N_ENG = 8,
  parameter int unsigned OFF_W = 16,
  parameter int unsigned PKT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sod,
  input  logic             en,
  input  logic [N_ENG-1:0] eng_out,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [N_ENG-1:0] ev_vec,
  output logic [OFF_W-1:0] ev_off,
  output logic [PKT_W-1:0] ev_pkt,
  output logic             ovf,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [N_ENG-1:0] prev_q, prev_d;
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;

  logic [N_ENG-1:0] vec_mem_q [DEPTH];
  logic [OFF_W-1:0] off_mem_q [DEPTH];
  logic [PKT_W-1:0] pkt_mem_q [DEPTH];

  logic [N_ENG-1:0] rise_c;
  logic             push_req_c, push_c, pop_c;

  // Rise detection and push/pop decisions
  always_comb begin
    rise_c     = sod ? '0 : (eng_out & ~prev_q);
    push_req_c = (rise_c != '0);
    pop_c      = (count_q != '0) && ev_ready;
    push_c     = push_req_c && ((count_q < CW'(DEPTH)) || pop_c);
  end

  // Next-state for counters, pointers and overflow tracking
  always_comb begin
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    prev_d  = eng_out;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (sod) begin
      cnt_d  = '0;
      pkt_d  = pkt_q + PKT_W'(1);
      prev_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + OFF_W'(1);
    end
    if (pop_c)  rd_d = rd_q + AW'(1);
    if (push_c) wr_d = wr_q + AW'(1);
    if (push_req_c && !push_c) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      pkt_q   <= '0;
      prev_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      prev_q  <= prev_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Event storage; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (rst && push_c) begin
      vec_mem_q[wr_q] <= rise_c;
      off_mem_q[wr_q] <= cnt_q - OFF_W'(1);
      pkt_mem_q[wr_q] <= pkt_q;
    end
  end

  // Head presentation, zeroed when empty
  always_comb begin
    ev_valid = (count_q != '0);
    ev_vec   = '0;
    ev_off   = '0;
    ev_pkt   = '0;
    if (ev_valid) begin
      ev_vec = vec_mem_q[rd_q];
      ev_off = off_mem_q[rd_q];
      ev_pkt = pkt_mem_q[rd_q];
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_nfa_match_reporter.sv
// Directed bench for nfa_match_reporter (N_ENG=8, OFF_W=16, PKT_W=8, DEPTH=4).
module tb_nfa_match_reporter;

  logic        clk = 1'b0;
  logic        rst, sod, en, ev_ready;
  logic [7:0]  eng_out;
  logic        ev_valid, ovf;
  logic [7:0]  ev_vec, drop_cnt;
  logic [15:0] ev_off;
  logic [7:0]  ev_pkt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nfa_match_reporter #(.N_ENG(8), .OFF_W(16), .PKT_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sod(sod), .en(en), .eng_out(eng_out),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_vec(ev_vec),
    .ev_off(ev_off), .ev_pkt(ev_pkt), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [7:0] v, input logic [15:0] o,
                      input logic [7:0] p);
    chk({tag, ".valid"}, 32'(ev_valid), 32'd1);
    chk({tag, ".vec"},   32'(ev_vec),   32'(v));
    chk({tag, ".off"},   32'(ev_off),   32'(o));
    chk({tag, ".pkt"},   32'(ev_pkt),   32'(p));
  endtask

  initial begin
    rst = 1'b0; sod = 1'b0; en = 1'b0; ev_ready = 1'b0; eng_out = 8'h00;
    tick(); tick();
    chk("rst.valid", 32'(ev_valid), 32'd0);
    chk("rst.vec",   32'(ev_vec),   32'd0);
    chk("rst.off",   32'(ev_off),   32'd0);
    chk("rst.ovf",   32'(ovf),      32'd0);
    chk("rst.drop",  32'(drop_cnt), 32'd0);
    rst = 1'b1;

    // Packet 1: five bytes, engine 3 rises after byte 4
    sod = 1'b1; tick(); sod = 1'b0;
    en = 1'b1; repeat (5) tick(); en = 1'b0;
    eng_out = 8'h08;
    chk("t1.valid_rise_cycle", 32'(ev_valid), 32'd0);
    tick();
    head("t1", 8'h08, 16'd4, 8'd1);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    chk("t1.popped", 32'(ev_valid), 32'd0);

    // Engines 0 and 5 rise together after byte 9
    en = 1'b1; repeat (5) tick(); en = 1'b0;
    eng_out = 8'h29; tick();
    head("t2", 8'h21, 16'd9, 8'd1);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    en = 1'b1; repeat (3) tick(); en = 1'b0;
    chk("t2.no_repeat", 32'(ev_valid), 32'd0);

    // Packet 2: six separate rises with ready low -> 4 queued, 2 dropped
    eng_out = 8'h00; sod = 1'b1; tick(); sod = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = 1'b1; tick(); en = 1'b0;
      eng_out = eng_out | 8'(1 << i); tick();
    end
    chk("t3.ovf",  32'(ovf),      32'd1);
    chk("t3.drop", 32'(drop_cnt), 32'd2);
    head("t3.h0", 8'h01, 16'd0, 8'd2);

    // Full FIFO: pop and push in the same cycle, no drop
    en = 1'b1; tick(); en = 1'b0;
    eng_out = eng_out | 8'h40; ev_ready = 1'b1; tick();
    chk("t4.drop", 32'(drop_cnt), 32'd2);
    head("t4.h1", 8'h02, 16'd1, 8'd2); tick();
    head("t4.h2", 8'h04, 16'd2, 8'd2); tick();
    head("t4.h3", 8'h08, 16'd3, 8'd2); tick();
    head("t4.h4", 8'h40, 16'd6, 8'd2); tick();
    chk("t4.empty", 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;

    // Event pending across sod; sod+en byte not counted
    en = 1'b1; tick(); en = 1'b0;
    eng_out = eng_out | 8'h80; tick();
    eng_out = 8'h00; sod = 1'b1; en = 1'b1; tick(); sod = 1'b0;
    tick(); en = 1'b0;
    eng_out = 8'h10; tick();
    head("t5.old", 8'h80, 16'd7, 8'd2);
    ev_ready = 1'b1; tick();
    head("t5.new", 8'h10, 16'd0, 8'd3);
    tick();
    chk("t5.empty", 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;

    // Reset with 3 events queued and ovf set
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; tick(); en = 1'b0;
      eng_out = eng_out | 8'(1 << i); tick();
    end
    head("t6.pre", 8'h01, 16'd1, 8'd3);
    rst = 1'b0; eng_out = 8'h00; tick(); rst = 1'b1;
    chk("t6.valid", 32'(ev_valid), 32'd0);
    chk("t6.vec",   32'(ev_vec),   32'd0);
    chk("t6.ovf",   32'(ovf),      32'd0);
    chk("t6.drop",  32'(drop_cnt), 32'd0);
    sod = 1'b1; tick(); sod = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    eng_out = 8'h02; tick();
    head("t6.post", 8'h02, 16'd0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
